// File: rtl/binary_addsub_pkg.sv
// Shared constants for the registered add/subtract unit.
package binary_addsub_pkg;

    localparam logic MODE_ADD      = 1'b0;
    localparam logic MODE_SUB      = 1'b1;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/binary_addsub_full_adder.sv
// One-bit full adder cell; chained by binary_addsub to form the ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/binary_addsub.sv
// Single-stage two's-complement adder/subtractor with carry and signed-overflow flags.
module binary_addsub
    import binary_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s_comb;
    logic [WIDTH:0]   c;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             out_valid_d, out_valid_q;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
    assign sub  = (mode == MODE_SUB);
    assign c[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        assign bx[i] = B[i] ^ sub;
        full_adder u_fa (
            .a    (A[i]),
            .b    (bx[i]),
            .cin  (c[i]),
            .s    (s_comb[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d      = s_comb;
            carry_d    = c[WIDTH];
            overflow_d = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_binary_addsub.sv
// Self-checking bench for binary_addsub at WIDTH = 4: directed table, reset/hold sequences, random run.
module tb_binary_addsub;
    import binary_addsub_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       mode_i;
    logic [3:0] sum_o;
    logic       carry_o;
    logic       overflow_o;
    logic       out_valid_o;

    int checks   = 0;
    int failures = 0;

    binary_addsub #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_i),
        .B         (b_i),
        .mode      (mode_i),
        .sum       (sum_o),
        .carry     (carry_o),
        .overflow  (overflow_o),
        .out_valid (out_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic m, input logic v);
        @(negedge clk);
        a_i      = a;
        b_i      = b;
        mode_i   = m;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic m,
                         output logic [3:0] s, output logic c, output logic v);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        if (m == MODE_ADD) begin
            s = 4'((ua + ub) % 16);
            c = (ua + ub) >= 16;
            r = sa + sb;
        end else begin
            s = 4'((ua - ub + 16) % 16);
            c = ua >= ub;
            r = sa - sb;
        end
        v = (r > 7) || (r < -8);
    endtask

    initial begin
        logic [3:0] es;
        logic       ec, ev;
        logic [3:0] ra, rb;
        logic       rm;

        vecs[0] = '{a: 4'd5, b: 4'd3, m: MODE_ADD, s: 4'd8,  c: 1'b0, v: 1'b1};
        vecs[1] = '{a: 4'd7, b: 4'd9, m: MODE_ADD, s: 4'd0,  c: 1'b1, v: 1'b0};
        vecs[2] = '{a: 4'd5, b: 4'd3, m: MODE_SUB, s: 4'd2,  c: 1'b1, v: 1'b0};
        vecs[3] = '{a: 4'd3, b: 4'd5, m: MODE_SUB, s: 4'd14, c: 1'b0, v: 1'b0};
        vecs[4] = '{a: 4'd8, b: 4'd1, m: MODE_SUB, s: 4'd7,  c: 1'b1, v: 1'b1};
        vecs[5] = '{a: 4'd0, b: 4'd0, m: MODE_SUB, s: 4'd0,  c: 1'b1, v: 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a_i      = 4'd5;
        b_i      = 4'd3;
        mode_i   = MODE_ADD;

        // Reset held two cycles with a live operation: it must be discarded.
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum", sum_o, 0);
        check("reset_carry", carry_o, 0);
        check("reset_overflow", overflow_o, 0);
        check("reset_out_valid", out_valid_o, 0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].m, 1'b1);
            check($sformatf("vec%0d_sum", i), sum_o, vecs[i].s);
            check($sformatf("vec%0d_carry", i), carry_o, vecs[i].c);
            check($sformatf("vec%0d_overflow", i), overflow_o, vecs[i].v);
            check($sformatf("vec%0d_out_valid", i), out_valid_o, 1);
        end

        // Hold: outputs keep the last result while in_valid is low.
        apply(4'd5, 4'd3, MODE_SUB, 1'b1);
        check("hold_pre_sum", sum_o, 2);
        apply(4'd15, 4'd15, MODE_ADD, 1'b0);
        check("hold_sum", sum_o, 2);
        check("hold_carry", carry_o, 1);
        check("hold_overflow", overflow_o, 0);
        check("hold_out_valid", out_valid_o, 0);
        apply(4'd15, 4'd15, MODE_ADD, 1'b0);
        check("hold2_sum", sum_o, 2);

        // Reset mid-stream clears a held result.
        @(negedge clk);
        rst_n = 1'b0;
        apply(4'd7, 4'd7, MODE_ADD, 1'b1);
        check("rst2_sum", sum_o, 0);
        check("rst2_carry", carry_o, 0);
        check("rst2_out_valid", out_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd7, 4'd7, MODE_ADD, 1'b1);
        check("post_rst_sum", sum_o, 14);
        check("post_rst_overflow", overflow_o, 1);
        check("post_rst_out_valid", out_valid_o, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            rm = 1'($urandom_range(1, 0));
            model(ra, rb, rm, es, ec, ev);
            apply(ra, rb, rm, 1'b1);
            check($sformatf("rnd%0d_sum a=%0d b=%0d m=%0d", i, ra, rb, rm), sum_o, es);
            check($sformatf("rnd%0d_carry a=%0d b=%0d m=%0d", i, ra, rb, rm), carry_o, ec);
            check($sformatf("rnd%0d_overflow a=%0d b=%0d m=%0d", i, ra, rb, rm), overflow_o, ev);
            check($sformatf("rnd%0d_out_valid", i), out_valid_o, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
